rle_decoder: RTL



---
 rtl/rle_decoder.sv | 93 +++++++++
 1 files changed

// File: rtl/rle_decoder.sv
// Streaming run-length decoder: expands (count, symbol) pairs into repeated
// symbols on a valid/ready stream, with a sticky zero-run flag and a beat counter.
//
//   state  | meaning
//   -------+--------------------------------------------
//   IDLE   | no run held, ready for a new pair
//   EXPAND | run held, m_valid=1, emitting m_data beats
module rle_decoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int STAT_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CNT_W-1:0]  s_count,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              clr_stats,
    output logic              err_zero_run,
    output logic [STAT_W-1:0] sym_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic              last_pend;
    logic              last_beat;
    logic              out_hs;
    logic              accept;
    logic              zero_pair;

    assign out_hs    = m_valid && m_ready;
    assign last_beat = (remaining == CNT_W'(1));
    assign s_ready   = !ARESET && ((state == IDLE) || (out_hs && last_beat));
    assign accept    = s_valid && s_ready;
    assign zero_pair = (s_count == '0);
    assign m_last    = m_valid && last_pend && last_beat;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            remaining <= '0;
            last_pend <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
        end else if (accept && !zero_pair) begin
            state     <= EXPAND;
            remaining <= s_count;
            last_pend <= s_last;
            m_valid   <= 1'b1;
            m_data    <= s_data;
        end else if (out_hs) begin
            // A zero-count pair taken on the last beat lands here too: the
            // pair is dropped and the run simply ends.
            if (last_beat) begin
                state     <= IDLE;
                remaining <= '0;
                last_pend <= 1'b0;
                m_valid   <= 1'b0;
            end else begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_zero_run <= 1'b0;
            sym_count    <= '0;
        end else begin
            if (accept && zero_pair)
                err_zero_run <= 1'b1;
            else if (clr_stats)
                err_zero_run <= 1'b0;

            if (clr_stats)
                sym_count <= '0;
            else if (out_hs)
                sym_count <= sym_count + STAT_W'(1);
        end
    end

endmodule
